// File: rtl/stream_demux.sv
// Registered 1-to-NCH stream demultiplexer.
// Per-channel holding registers, broadcast, drop accounting.
module stream_demux #(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int SW  = 2,
  parameter int CW  = 8
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [SW-1:0]     in_sel,
  input  logic              in_bcast,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*DW-1:0] out_data,
  output logic              drop_pulse,
  output logic [CW-1:0]     drop_cnt
);

  localparam int NP = 2**SW;
  localparam logic [SW:0] NCH_W = (SW+1)'(NCH);

  logic [NCH-1:0] free;
  logic [NCH-1:0] load;
  logic [NP-1:0]  free_pad;
  logic           sel_ok;
  logic           accept;
  logic           drop;

  assign free   = ~out_valid | out_ready;
  assign sel_ok = {1'b0, in_sel} < NCH_W;

  always_comb begin
    free_pad = '0;
    free_pad[NCH-1:0] = free;
  end

  always_comb begin
    in_ready = 1'b0;
    if (!rst_n)
      in_ready = 1'b0;
    else if (in_bcast)
      in_ready = &free;
    else if (sel_ok)
      in_ready = free_pad[in_sel];
    else
      in_ready = 1'b1;
  end

  assign accept = in_valid && in_ready;
  assign drop   = accept && !in_bcast && !sel_ok;

  for (genvar i = 0; i < NCH; i++) begin : g_ld
    assign load[i] = accept &&
                     (in_bcast || in_sel == SW'(i));
  end

  // a load wins over a same-cycle drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (load[i]) begin
          out_valid[i]         <= 1'b1;
          out_data[i*DW +: DW] <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= drop;
      if (drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux.
// Two instances: NCH=4/CW=8 and NCH=3/CW=2.
module tb_stream_demux;

  logic clk;
  logic rst_n;

  logic        a_valid;
  logic        a_ready;
  logic [7:0]  a_data;
  logic [1:0]  a_sel;
  logic        a_bcast;
  logic [3:0]  a_ovalid;
  logic [3:0]  a_oready;
  logic [31:0] a_odata;
  logic        a_dpulse;
  logic [7:0]  a_dcnt;

  logic        b_valid;
  logic        b_ready;
  logic [7:0]  b_data;
  logic [1:0]  b_sel;
  logic        b_bcast;
  logic [2:0]  b_ovalid;
  logic [2:0]  b_oready;
  logic [23:0] b_odata;
  logic        b_dpulse;
  logic [1:0]  b_dcnt;

  int errors = 0;
  int checks = 0;

  stream_demux #(
    .NCH(4), .DW(8), .SW(2), .CW(8)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .in_sel(a_sel),
    .in_bcast(a_bcast),
    .out_valid(a_ovalid), .out_ready(a_oready),
    .out_data(a_odata),
    .drop_pulse(a_dpulse), .drop_cnt(a_dcnt)
  );

  stream_demux #(
    .NCH(3), .DW(8), .SW(2), .CW(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .in_sel(b_sel),
    .in_bcast(b_bcast),
    .out_valid(b_ovalid), .out_ready(b_oready),
    .out_data(b_odata),
    .drop_pulse(b_dpulse), .drop_cnt(b_dcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_cnt;
    rst_n    = 1'b0;
    a_valid  = 1'b0;
    a_data   = 8'h00;
    a_sel    = 2'd0;
    a_bcast  = 1'b0;
    a_oready = 4'hF;
    b_valid  = 1'b0;
    b_data   = 8'h00;
    b_sel    = 2'd0;
    b_bcast  = 1'b0;
    b_oready = 3'h7;
    #2;
    check("rst_in_ready", a_ready, 0);
    check("rst_out_valid", a_ovalid, 0);
    check("rst_out_data", a_odata, 0);
    check("rst_drop_cnt", b_dcnt, 0);
    tick;
    tick;
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", a_ready, 1);

    // single beat to channel 2
    a_valid = 1'b1;
    a_sel   = 2'd2;
    a_data  = 8'hA1;
    tick;
    a_valid = 1'b0;
    check("sel2_valid", a_ovalid, 32'h4);
    check("sel2_data", a_odata, 32'h00A10000);
    tick;
    check("sel2_drain", a_ovalid, 0);

    // back-pressure on channel 1
    a_oready = 4'b1101;
    a_valid  = 1'b1;
    a_sel    = 2'd1;
    a_data   = 8'h11;
    tick;
    check("bp_first", a_odata[15:8], 32'h11);
    a_data = 8'h22;
    #1;
    check("bp_ready_low", a_ready, 0);
    tick;
    check("bp_hold_data", a_odata[15:8], 32'h11);
    check("bp_hold_valid", a_ovalid, 32'h2);
    a_oready = 4'hF;
    #1;
    check("bp_ready_up", a_ready, 1);
    tick;
    a_valid = 1'b0;
    check("bp_second", a_odata[15:8], 32'h22);
    check("bp_second_v", a_ovalid, 32'h2);
    tick;

    // stall ch0, stream to ch3
    a_oready = 4'b1110;
    a_valid  = 1'b1;
    a_sel    = 2'd0;
    a_data   = 8'h0F;
    tick;
    for (int k = 0; k < 8; k++) begin
      a_sel  = 2'd3;
      a_data = 8'h30 + 8'(k);
      #1;
      check("ind_ready", a_ready, 1);
      tick;
      check("ind_data", a_odata[31:24],
            32'h30 + 32'(k));
      check("ind_valid", a_ovalid[3], 1);
    end
    a_valid = 1'b0;
    check("ind_ch0_hold", a_odata[7:0], 32'h0F);
    tick;

    // broadcast against stalled ch2
    a_oready = 4'b1011;
    a_valid  = 1'b1;
    a_sel    = 2'd2;
    a_data   = 8'h77;
    tick;
    a_bcast = 1'b1;
    a_sel   = 2'd1;
    a_data  = 8'h5A;
    #1;
    check("bc_blocked", a_ready, 0);
    tick;
    check("bc_only_ch2", a_ovalid, 32'h4);
    a_oready = 4'hF;
    #1;
    check("bc_ready", a_ready, 1);
    tick;
    a_valid = 1'b0;
    a_bcast = 1'b0;
    check("bc_all_v", a_ovalid, 32'hF);
    check("bc_all_d", a_odata, 32'h5A5A5A5A);
    tick;

    // out-of-range beats on the 3-channel instance
    exp_cnt = 2'd0;
    for (int k = 0; k < 5; k++) begin
      b_valid = 1'b1;
      b_sel   = 2'd3;
      b_data  = 8'hC0 + 8'(k);
      #1;
      check("drp_ready", b_ready, 1);
      tick;
      if (exp_cnt != 2'd3)
        exp_cnt = exp_cnt + 2'd1;
      check("drp_pulse", b_dpulse, 1);
      check("drp_cnt", b_dcnt, exp_cnt);
      check("drp_no_out", b_ovalid, 0);
    end
    b_valid = 1'b0;
    tick;
    check("drp_pulse_off", b_dpulse, 0);
    b_valid = 1'b1;
    b_bcast = 1'b1;
    b_data  = 8'hE7;
    tick;
    b_valid = 1'b0;
    b_bcast = 1'b0;
    check("bc3_no_drop", b_dpulse, 0);
    check("bc3_valid", b_ovalid, 32'h7);
    check("bc3_data", b_odata, 32'hE7E7E7);
    check("bc3_cnt", b_dcnt, 3);

    // reset while ch0/ch1 hold beats
    a_oready = 4'b1100;
    a_valid  = 1'b1;
    a_sel    = 2'd0;
    a_data   = 8'h01;
    tick;
    a_sel  = 2'd1;
    a_data = 8'h02;
    tick;
    a_valid = 1'b0;
    check("pre_rst_v", a_ovalid, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_v", a_ovalid, 0);
    check("mid_rst_d", a_odata, 0);
    check("mid_rst_cnt", b_dcnt, 0);
    check("mid_rst_rdy", a_ready, 0);
    tick;
    rst_n = 1'b1;
    #1;
    check("post_rst_rdy", a_ready, 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
